// File: rtl/adxl362_spi_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adxl362_spi_responder_pkg
// Description : Opcodes, register map, ID bytes and FSM encoding for the
//               ADXL362 SPI responder.
// Revision    : 1.0 - initial release
// ============================================================================
package adxl362_spi_responder_pkg;

    localparam logic [7:0] CMD_WR         = 8'h0A;
    localparam logic [7:0] CMD_RD         = 8'h0B;
    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    localparam logic [7:0] ID_AD   = 8'hAD;
    localparam logic [7:0] ID_MST  = 8'h1D;
    localparam logic [7:0] ID_PART = 8'hF2;
    localparam logic [7:0] ID_REV  = 8'h01;

    localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
    localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
    localparam logic [5:0] ADDR_PARTID    = 6'h02;
    localparam logic [5:0] ADDR_REVID     = 6'h03;
    localparam logic [5:0] ADDR_XDATA     = 6'h08;
    localparam logic [5:0] ADDR_YDATA     = 6'h09;
    localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
    localparam logic [5:0] ADDR_STATUS    = 6'h0B;
    localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
    localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
    localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
    localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
    localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
    localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
    localparam logic [5:0] ADDR_TEMP_L    = 6'h14;
    localparam logic [5:0] ADDR_TEMP_H    = 6'h15;
    localparam logic [5:0] ADDR_SOFT_RST  = 6'h1F;
    localparam logic [5:0] ADDR_RW_FIRST  = 6'h20;
    localparam logic [5:0] ADDR_RW_LAST   = 6'h2E;

    // Index of a control register inside the 0x20-0x2F bank
    localparam int IDX_FILTER_CTL = 12;
    localparam int IDX_POWER_CTL  = 13;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_CMD     = 3'd1;
    localparam logic [STATE_W-1:0] ST_ADDR    = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA_WR = 3'd3;
    localparam logic [STATE_W-1:0] ST_DATA_RD = 3'd4;
    localparam logic [STATE_W-1:0] ST_IGNORE  = 3'd5;

    // High byte of a 12-bit sample: sign extended into bits 7:4
    function automatic logic [7:0] sample_hi(input logic [11:0] v);
        return {{4{v[11]}}, v[11:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/adxl362_spi_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : adxl362_spi_responder_if
// Description : SPI bus lines between the accelerometer controller (master)
//               and the ADXL362 responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface adxl362_spi_responder_if;
    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output mosi, output cs_n, input miso, input miso_oe);
    modport slave  (input sclk, input mosi, input cs_n, output miso, output miso_oe);
endinterface
`default_nettype wire

// File: rtl/adxl362_spi_responder_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_sync
// Description : Synchronises sclk/mosi/cs_n into clk and emits one-cycle
//               edge pulses; o_mosi is delayed to line up with the pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_sclk,
    input  wire logic i_mosi,
    input  wire logic i_cs_n,
    output logic      o_mosi,
    output logic      o_sclk_rise,
    output logic      o_sclk_fall,
    output logic      o_cs_fall,
    output logic      o_cs_rise
);
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            o_mosi      <= 1'b0;
            o_sclk_rise <= 1'b0;
            o_sclk_fall <= 1'b0;
            o_cs_fall   <= 1'b0;
            o_cs_rise   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
            o_mosi      <= r_mosi_sync[SYNC_STAGES-1];
            o_sclk_rise <=  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
            o_sclk_fall <= ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_d;
            o_cs_fall   <= ~r_cs_sync[SYNC_STAGES-1]   &  r_cs_d;
            o_cs_rise   <=  r_cs_sync[SYNC_STAGES-1]   & ~r_cs_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/adxl362_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : adxl362_spi_responder
// Description : ADXL362 SPI mode-0 slave model serving ID, sample, status
//               and control registers to the accelerometer controller.
// Revision    : 1.0 - initial release
// ============================================================================
module adxl362_spi_responder
    import adxl362_spi_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILTER_RST  = 8'h13
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    adxl362_spi_responder_if.slave     spi,
    input  wire logic [11:0]           x_in,
    input  wire logic [11:0]           y_in,
    input  wire logic [11:0]           z_in,
    input  wire logic [11:0]           temp_in,
    input  wire logic                  sample_valid,
    output logic [7:0]                 power_ctl,
    output logic [7:0]                 filter_ctl,
    output logic                       reg_wr,
    output logic                       cmd_error
);
    logic               w_mosi, w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic [STATE_W-1:0] r_state, w_state_nxt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift, r_tx, w_rx_byte, w_rdata;
    logic [5:0]         r_addr;
    logic               r_is_read, r_miso, r_oe, r_touched, r_drdy;
    logic               w_byte_done, w_cmd_err, w_wr_commit, w_wr_ok, w_in_ctl;
    logic [11:0]        r_x, r_y, r_z, r_t, r_sx, r_sy, r_sz, r_st;
    logic [7:0]         r_ctl [16];

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .rst         (reset),
        .i_sclk      (spi.sclk),
        .i_mosi      (spi.mosi),
        .i_cs_n      (spi.cs_n),
        .o_mosi      (w_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs_fall   (w_cs_fall),
        .o_cs_rise   (w_cs_rise)
    );

    assign w_rx_byte   = {r_shift[6:0], w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_in_ctl    = (r_addr >= ADDR_RW_FIRST) && (r_addr <= ADDR_RW_LAST);
    assign w_wr_ok     = w_in_ctl || (r_addr == ADDR_SOFT_RST);

    assign spi.miso    = r_miso;
    assign spi.miso_oe = r_oe & ~w_cs_rise;
    assign filter_ctl  = r_ctl[IDX_FILTER_CTL];
    assign power_ctl   = r_ctl[IDX_POWER_CTL];

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_err   = 1'b0;
        w_wr_commit = 1'b0;
        if (w_cs_rise) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_cs_fall) w_state_nxt = ST_CMD;
                ST_CMD: begin
                    if (w_byte_done) begin
                        if (w_rx_byte == CMD_WR || w_rx_byte == CMD_RD) begin
                            w_state_nxt = ST_ADDR;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                            w_cmd_err   = 1'b1;
                        end
                    end
                end
                ST_ADDR:    if (w_byte_done) w_state_nxt = r_is_read ? ST_DATA_RD : ST_DATA_WR;
                ST_DATA_WR: w_wr_commit = w_byte_done;
                default:    ;
            endcase
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (r_addr)
            ADDR_DEVID_AD:  w_rdata = ID_AD;
            ADDR_DEVID_MST: w_rdata = ID_MST;
            ADDR_PARTID:    w_rdata = ID_PART;
            ADDR_REVID:     w_rdata = ID_REV;
            ADDR_XDATA:     w_rdata = r_sx[11:4];
            ADDR_YDATA:     w_rdata = r_sy[11:4];
            ADDR_ZDATA:     w_rdata = r_sz[11:4];
            ADDR_STATUS:    w_rdata = {7'b0, r_drdy};
            ADDR_XDATA_L:   w_rdata = r_sx[7:0];
            ADDR_XDATA_H:   w_rdata = sample_hi(r_sx);
            ADDR_YDATA_L:   w_rdata = r_sy[7:0];
            ADDR_YDATA_H:   w_rdata = sample_hi(r_sy);
            ADDR_ZDATA_L:   w_rdata = r_sz[7:0];
            ADDR_ZDATA_H:   w_rdata = sample_hi(r_sz);
            ADDR_TEMP_L:    w_rdata = r_st[7:0];
            ADDR_TEMP_H:    w_rdata = sample_hi(r_st);
            default:        if (w_in_ctl) w_rdata = r_ctl[r_addr[3:0]];
        endcase
    end

    // Serial datapath: shift-in on rise, shift-out on fall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 8'h00;
            r_addr    <= 6'h00;
            r_is_read <= 1'b0;
            r_miso    <= 1'b0;
            r_oe      <= 1'b0;
            r_touched <= 1'b0;
            reg_wr    <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            reg_wr    <= 1'b0;
            cmd_error <= w_cmd_err;
            if (r_state == ST_IDLE || w_cs_rise) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sclk_rise) begin
                r_shift   <= w_rx_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_state == ST_CMD && w_byte_done) r_is_read <= (w_rx_byte == CMD_RD);
            if (r_state == ST_ADDR && w_byte_done) r_addr <= w_rx_byte[5:0];
            if (w_wr_commit) begin
                reg_wr <= w_wr_ok;
                r_addr <= r_addr + 6'd1;
            end
            if (r_state == ST_DATA_RD && w_sclk_fall && !w_cs_rise) begin
                if (r_bit_cnt == 3'd0) begin
                    r_tx   <= {w_rdata[6:0], 1'b0};
                    r_miso <= w_rdata[7];
                    r_oe   <= 1'b1;
                    r_addr <= r_addr + 6'd1;
                    if (r_addr >= ADDR_XDATA && r_addr <= ADDR_TEMP_H) r_touched <= 1'b1;
                end else begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
            end
            if (w_cs_rise) begin
                r_oe      <= 1'b0;
                r_miso    <= 1'b0;
                r_touched <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_ctl[i] <= (i == IDX_FILTER_CTL) ? FILTER_RST : 8'h00;
        end else if (w_wr_commit && w_wr_ok) begin
            if (r_addr == ADDR_SOFT_RST) begin
                if (w_rx_byte == SOFT_RESET_KEY)
                    for (int i = 0; i < 16; i++) r_ctl[i] <= (i == IDX_FILTER_CTL) ? FILTER_RST : 8'h00;
            end else begin
                r_ctl[r_addr[3:0]] <= w_rx_byte;
            end
        end
    end

    // Shadow copy at frame start keeps multi-byte sample reads coherent
    always_ff @(posedge clk) begin
        if (reset) begin
            {r_x, r_y, r_z, r_t}     <= '0;
            {r_sx, r_sy, r_sz, r_st} <= '0;
            r_drdy                   <= 1'b0;
        end else begin
            if (w_cs_fall) {r_sx, r_sy, r_sz, r_st} <= {r_x, r_y, r_z, r_t};
            if (sample_valid) begin
                {r_x, r_y, r_z, r_t} <= {x_in, y_in, z_in, temp_in};
                r_drdy               <= 1'b1;
            end else if (w_cs_rise && r_touched) begin
                r_drdy <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_adxl362_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adxl362_spi_responder
// Description : Directed SPI-master bench for adxl362_spi_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adxl362_spi_responder;

    typedef struct packed {
        logic [2:0]  n;
        logic [47:0] tx;
        logic [47:0] ex;
        logic        oe;
        logic [7:0]  pw;
        logic [7:0]  fl;
        logic [1:0]  wr;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] x_in, y_in, z_in, temp_in;
    logic        sample_valid;
    logic [7:0]  power_ctl, filter_ctl;
    logic        reg_wr, cmd_error;
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          err_cnt = 0;
    vec_t        vecs [16];

    adxl362_spi_responder_if spi ();

    adxl362_spi_responder #(.SYNC_STAGES(2), .FILTER_RST(8'h13)) dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .temp_in      (temp_in),
        .sample_valid (sample_valid),
        .power_ctl    (power_ctl),
        .filter_ctl   (filter_ctl),
        .reg_wr       (reg_wr),
        .cmd_error    (cmd_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_wr)    wr_cnt++;
        if (cmd_error) err_cnt++;
    end

    function automatic vec_t mkv(input int n, input logic [47:0] tx, input logic [47:0] ex,
                                 input logic oe, input logic [7:0] pw, input logic [7:0] fl,
                                 input int wr, input logic err);
        vec_t v;
        v.n = 3'(n); v.tx = tx; v.ex = ex; v.oe = oe;
        v.pw = pw; v.fl = fl; v.wr = 2'(wr); v.err = err;
        return v;
    endfunction

    function automatic logic [7:0] byte_of(input logic [47:0] w, input int b);
        return w[47 - 8*b -: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi.cs_n = 1'b0;
        clocks(5);
    endtask

    task automatic cs_high();
        clocks(5);
        spi.cs_n = 1'b1;
        clocks(10);
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe_any);
        rx = 8'h00;
        oe_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi.mosi = tx[i];
            clocks(5);
            spi.sclk = 1'b1;
            rx[i]    = spi.miso;
            oe_any   = oe_any | spi.miso_oe;
            clocks(5);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic read_regs(input logic [7:0] addr, input int n, output logic [31:0] d);
        logic [7:0] rx;
        logic       oe;
        d = 32'h0;
        cs_low();
        xfer_byte(8'h0B, rx, oe);
        xfer_byte(addr, rx, oe);
        for (int b = 0; b < n; b++) begin
            xfer_byte(8'h00, rx, oe);
            d = {d[23:0], rx};
        end
        cs_high();
    endtask

    task automatic strobe(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z,
                          input logic [11:0] t);
        x_in = x; y_in = y; z_in = z; temp_in = t;
        sample_valid = 1'b1;
        clocks(1);
        sample_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] rx;
        logic       oe, oe_pre, oe_dat;
        int         wr0, er0;
        wr0 = wr_cnt; er0 = err_cnt; oe_pre = 1'b0; oe_dat = 1'b0;
        cs_low();
        for (int b = 0; b < int'(v.n); b++) begin
            xfer_byte(byte_of(v.tx, b), rx, oe);
            if (b < 2) oe_pre = oe_pre | oe;
            else       oe_dat = oe_dat | oe;
            if (b >= 2 && v.oe) check($sformatf("vec%0d rd byte%0d", idx, b), rx, byte_of(v.ex, b));
        end
        cs_high();
        check($sformatf("vec%0d oe in cmd/addr", idx), oe_pre, 0);
        check($sformatf("vec%0d oe in data", idx), oe_dat, v.oe);
        check($sformatf("vec%0d oe after cs", idx), spi.miso_oe, 0);
        check($sformatf("vec%0d power_ctl", idx), power_ctl, v.pw);
        check($sformatf("vec%0d filter_ctl", idx), filter_ctl, v.fl);
        check($sformatf("vec%0d reg_wr pulses", idx), wr_cnt - wr0, v.wr);
        check($sformatf("vec%0d cmd_error pulses", idx), err_cnt - er0, v.err);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  rx;
        logic        oe;

        vecs[0]  = mkv(6, 48'h0B00_0000_0000, 48'h0000_AD1D_F201, 1, 8'h00, 8'h13, 0, 0);
        vecs[1]  = mkv(3, 48'h0A2D_0200_0000, 48'h0,              0, 8'h02, 8'h13, 1, 0);
        vecs[2]  = mkv(3, 48'h0B2D_0000_0000, 48'h0000_0200_0000, 1, 8'h02, 8'h13, 0, 0);
        vecs[3]  = mkv(4, 48'h0A20_A55A_0000, 48'h0,              0, 8'h02, 8'h13, 2, 0);
        vecs[4]  = mkv(4, 48'h0B20_0000_0000, 48'h0000_A55A_0000, 1, 8'h02, 8'h13, 0, 0);
        vecs[5]  = mkv(5, 48'h0B3E_0000_0000, 48'h0000_0000_AD00, 1, 8'h02, 8'h13, 0, 0);
        vecs[6]  = mkv(3, 48'h0D12_3400_0000, 48'h0,              0, 8'h02, 8'h13, 0, 1);
        vecs[7]  = mkv(3, 48'h0B01_0000_0000, 48'h0000_1D00_0000, 1, 8'h02, 8'h13, 0, 0);
        vecs[8]  = mkv(3, 48'h0A2C_5500_0000, 48'h0,              0, 8'h02, 8'h55, 1, 0);
        vecs[9]  = mkv(3, 48'h0A1F_5200_0000, 48'h0,              0, 8'h00, 8'h13, 1, 0);
        vecs[10] = mkv(4, 48'h0B20_0000_0000, 48'h0000_0000_0000, 1, 8'h00, 8'h13, 0, 0);
        vecs[11] = mkv(3, 48'h0A05_7700_0000, 48'h0,              0, 8'h00, 8'h13, 0, 0);
        vecs[12] = mkv(3, 48'h0B05_0000_0000, 48'h0000_0000_0000, 1, 8'h00, 8'h13, 0, 0);
        vecs[13] = mkv(3, 48'h0A2D_0800_0000, 48'h0,              0, 8'h08, 8'h13, 1, 0);
        vecs[14] = mkv(3, 48'h0AEE_3C00_0000, 48'h0,              0, 8'h08, 8'h13, 1, 0);
        vecs[15] = mkv(3, 48'h0B2E_0000_0000, 48'h0000_3C00_0000, 1, 8'h08, 8'h13, 0, 0);

        reset = 1'b1;
        spi.sclk = 1'b0; spi.mosi = 1'b0; spi.cs_n = 1'b1;
        x_in = '0; y_in = '0; z_in = '0; temp_in = '0; sample_valid = 1'b0;
        clocks(4);
        reset = 1'b0;
        clocks(2);
        check("reset miso", spi.miso, 0);
        check("reset miso_oe", spi.miso_oe, 0);
        check("reset power_ctl", power_ctl, 8'h00);
        check("reset filter_ctl", filter_ctl, 8'h13);
        check("reset reg_wr", reg_wr, 0);
        check("reset cmd_error", cmd_error, 0);

        for (int v = 0; v < 16; v++) run_vec(vecs[v], v);

        // Sample path, status flag and clear-on-read
        strobe(12'h812, 12'h456, 12'hA00, 12'h000);
        read_regs(8'h0B, 1, d);  check("status before read", d[7:0], 8'h01);
        read_regs(8'h0E, 2, d);  check("x L/H", d[15:0], 16'h12F8);
        read_regs(8'h0B, 1, d);  check("status after read", d[7:0], 8'h00);
        read_regs(8'h08, 3, d);  check("xyz hi bytes", d[23:0], 24'h8145A0);
        read_regs(8'h10, 4, d);  check("y/z L/H", d, 32'h5604_00FA);

        // Sample update mid-frame must not disturb the frame's data
        strobe(12'h123, 12'h000, 12'h000, 12'h000);
        cs_low();
        xfer_byte(8'h0B, rx, oe);
        xfer_byte(8'h0E, rx, oe);
        xfer_byte(8'h00, rx, oe); check("shadow x L", rx, 8'h23);
        strobe(12'h7FF, 12'h000, 12'h000, 12'hF80);
        xfer_byte(8'h00, rx, oe); check("shadow x H", rx, 8'h01);
        cs_high();
        read_regs(8'h0E, 2, d);  check("x after update", d[15:0], 16'hFF07);
        read_regs(8'h14, 2, d);  check("temp L/H", d[15:0], 16'h80FF);

        // Reset asserted mid-byte during a read data phase
        cs_low();
        xfer_byte(8'h0B, rx, oe);
        xfer_byte(8'h00, rx, oe);
        xfer_byte(8'h00, rx, oe); check("pre-reset read", rx, 8'hAD);
        for (int i = 0; i < 3; i++) begin
            clocks(5); spi.sclk = 1'b1; clocks(5); spi.sclk = 1'b0;
        end
        check("oe before reset", spi.miso_oe, 1);
        spi.sclk = 1'b1;
        clocks(2);
        reset = 1'b1;
        clocks(2);
        check("reset mid-byte miso_oe", spi.miso_oe, 0);
        check("reset mid-byte miso", spi.miso, 0);
        reset = 1'b0;
        clocks(1);
        check("reset mid-byte power_ctl", power_ctl, 8'h00);
        check("reset mid-byte filter_ctl", filter_ctl, 8'h13);
        spi.sclk = 1'b0;
        clocks(5);
        spi.cs_n = 1'b1;
        clocks(10);
        check("post-reset oe idle", spi.miso_oe, 0);
        run_vec(vecs[0], 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
